// File: rtl/pmem_arbiter.sv
// Two-way arbiter sharing the 128-bit physical-memory port between I-cache and D-cache.
// Define PMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority (D wins).
module pmem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_pmem_read,
  input  logic         i_pmem_write,
  input  logic [15:0]  i_pmem_address,
  input  logic [127:0] i_pmem_wdata,
  output logic [127:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [15:0]  d_pmem_address,
  input  logic [127:0] d_pmem_wdata,
  output logic [127:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_grant;  // 0 = I, 1 = D
  logic   req_i, req_d;
  logic   conflict_grant_d;

  assign req_i = i_pmem_read | i_pmem_write;
  assign req_d = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  assign conflict_grant_d = ~last_grant;
`else
  // last_grant is tracked in both builds so the two configurations share one datapath.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign conflict_grant_d  = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous so the
  // outputs (decoded from state) drop the moment rst rises, not at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next != IDLE)
        last_grant <= (state_next == SERVE_D);
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req_i && req_d)
          state_next = conflict_grant_d ? SERVE_D : SERVE_I;
        else if (req_d)
          state_next = SERVE_D;
        else if (req_i)
          state_next = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grants never abort: once in SERVE_x only pmem_resp ends the transaction.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    unique case (state)
      SERVE_I: begin
        pmem_read    = i_pmem_read;
        pmem_write   = i_pmem_write;
        pmem_address = i_pmem_address;
        pmem_wdata   = i_pmem_wdata;
        i_pmem_resp  = pmem_resp;
      end
      SERVE_D: begin
        pmem_read    = d_pmem_read;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; each cache qualifies it with its own resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter; expectations follow PMEM_ARB_ROUND_ROBIN_EN.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read, i_pmem_write;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_wdata, i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read, d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata, d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] RDATA = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [127:0] WDATA = {16{8'hA5}};

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs and checks happen 1-2 time units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_d;
    rst = 1'b1;
    {i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write, pmem_resp} = '0;
    i_pmem_address = '0; d_pmem_address = '0;
    i_pmem_wdata = '0; d_pmem_wdata = '0; pmem_rdata = '0;
    #12;
    check("reset_rw", {126'd0, pmem_read, pmem_write}, 128'd0);
    check("reset_resp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'd0);
    rst = 1'b0;

    // Resp while idle must not be forwarded.
    tick();
    pmem_resp = 1'b1; #1;
    check("idle_resp_ignored", {126'd0, i_pmem_resp, d_pmem_resp}, 128'd0);
    pmem_resp = 1'b0;

    // Single I read with 3-cycle memory latency.
    tick();
    i_pmem_read = 1'b1; i_pmem_address = 16'h1230; #1;
    check("i_rd_arb_cycle", {127'd0, pmem_read}, 128'd0);
    tick();
    check("i_rd_read", {127'd0, pmem_read}, 128'd1);
    check("i_rd_addr", {112'd0, pmem_address}, 128'h1230);
    check("i_rd_noresp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'd0);
    tick();
    tick();
    pmem_resp = 1'b1; pmem_rdata = RDATA; #1;
    check("i_rd_resp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'b10);
    check("i_rd_rdata", i_pmem_rdata, RDATA);
    tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0; #1;
    check("i_rd_done", {125'd0, pmem_read, i_pmem_resp, d_pmem_resp}, 128'd0);

    // D write-back.
    d_pmem_write = 1'b1; d_pmem_address = 16'h4000; d_pmem_wdata = WDATA;
    tick();
    check("d_wr_write", {126'd0, pmem_read, pmem_write}, 128'b01);
    check("d_wr_addr", {112'd0, pmem_address}, 128'h4000);
    check("d_wr_wdata", pmem_wdata, WDATA);
    tick();
    check("d_wr_hold_addr", {112'd0, pmem_address}, 128'h4000);
    pmem_resp = 1'b1; #1;
    check("d_wr_resp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'b01);
    check("d_wr_wdata_at_resp", pmem_wdata, WDATA);
    tick();
    pmem_resp = 1'b0; d_pmem_write = 1'b0; #1;
    check("d_wr_dropped", {127'd0, pmem_write}, 128'd0);

    // Fresh reset so the conflict sequence starts with last_grant = I.
    rst = 1'b1; #2; rst = 1'b0;
    tick();
    i_pmem_read = 1'b1; i_pmem_address = 16'h1111;
    d_pmem_read = 1'b1; d_pmem_address = 16'h2222;
    for (int k = 0; k < 4; k++) begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      tick();
      check($sformatf("conflict%0d_addr", k), {112'd0, pmem_address},
            exp_d ? 128'h2222 : 128'h1111);
      pmem_resp = 1'b1; #1;
      check($sformatf("conflict%0d_resp", k), {126'd0, i_pmem_resp, d_pmem_resp},
            exp_d ? 128'b01 : 128'b10);
      tick();
      pmem_resp = 1'b0; #1;
      check($sformatf("conflict%0d_idle_gap", k), {127'd0, pmem_read}, 128'd0);
    end
    d_pmem_read = 1'b0;
    tick();
    check("i_after_conflicts_addr", {112'd0, pmem_address}, 128'h1111);
    pmem_resp = 1'b1; #1;
    check("i_after_conflicts_resp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'b10);
    tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0;

    // I request arrives while D is mid-transaction.
    d_pmem_read = 1'b1; d_pmem_address = 16'h3000;
    tick();
    check("busy_d_addr0", {112'd0, pmem_address}, 128'h3000);
    tick();
    i_pmem_read = 1'b1; i_pmem_address = 16'h5000; #1;
    check("busy_d_addr1", {112'd0, pmem_address}, 128'h3000);
    check("busy_i_waits", {126'd0, i_pmem_resp, d_pmem_resp}, 128'd0);
    tick();
    check("busy_d_addr2", {112'd0, pmem_address}, 128'h3000);
    pmem_resp = 1'b1; #1;
    check("busy_d_resp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'b01);
    tick();
    pmem_resp = 1'b0; d_pmem_read = 1'b0; #1;
    check("busy_idle_gap", {127'd0, pmem_read}, 128'd0);
    tick();
    check("busy_i_granted", {111'd0, pmem_read, pmem_address}, {111'd0, 1'b1, 16'h5000});
    pmem_resp = 1'b1; #1;
    check("busy_i_resp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'b10);
    tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0;

    // Asynchronous reset during SERVE_D.
    d_pmem_write = 1'b1; d_pmem_address = 16'h6000; d_pmem_wdata = WDATA;
    tick();
    check("rst_mid_write", {127'd0, pmem_write}, 128'd1);
    #2; rst = 1'b1; pmem_resp = 1'b1; #1;
    check("rst_mid_rw", {126'd0, pmem_read, pmem_write}, 128'd0);
    check("rst_mid_resp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'd0);
    check("rst_mid_addr", {112'd0, pmem_address}, 128'd0);
    d_pmem_write = 1'b0; pmem_resp = 1'b0;
    tick();
    rst = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 16'h7000;
    tick();
    check("post_rst_i", {111'd0, pmem_read, pmem_address}, {111'd0, 1'b1, 16'h7000});
    pmem_resp = 1'b1; pmem_rdata = RDATA; #1;
    check("post_rst_i_resp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'b10);
    tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0; #1;
    check("post_rst_idle", {127'd0, pmem_read}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
